// File: rtl/mips_fetch_pkg.sv
// mips_fetch_pkg: shared state encoding and PC constants for the fetch stage
package mips_fetch_pkg;
    typedef enum logic [1:0] {IDLE, BUSY, DISCARD} fetch_state_t;
    localparam logic [31:0] PC_RESET_DEFAULT = 32'h0040_0000;
    localparam logic [31:0] PC_STEP = 32'd4;
endpackage

// File: rtl/branch_target_unit.sv
// branch_target_unit: resolves BEQ/BNE taken flag and word-offset branch target
module branch_target_unit (
    input  logic        branch_eq,
    input  logic        branch_ne,
    input  logic        zero,
    input  logic [31:0] branch_pc4,
    input  logic [31:0] branch_imm,
    output logic        taken,
    output logic [31:0] target
);
    assign taken  = (branch_eq & zero) | (branch_ne & ~zero);
    assign target = branch_pc4 + {branch_imm[29:0], 2'b00};
endmodule

// File: rtl/instruction_fetch_unit.sv
// instruction_fetch_unit: MIPS fetch stage with branch redirect; FETCH_PERF_COUNTERS_EN adds FetchCount/StallCount
module instruction_fetch_unit
    import mips_fetch_pkg::*;
#(
    parameter logic [31:0] PC_RESET = PC_RESET_DEFAULT
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        Stall,
    input  logic        BranchEQ,
    input  logic        BranchNE,
    input  logic        Zero,
    input  logic [31:0] BranchPC4,
    input  logic [31:0] BranchImm,
    input  logic        IMemReady,
    input  logic [31:0] IMemData,
    output logic        IMemReq,
    output logic [31:0] IMemAddr,
    output logic        InstrValid,
    output logic [31:0] Instruction,
    output logic [31:0] PCPlus4
`ifdef FETCH_PERF_COUNTERS_EN
    ,
    output logic [31:0] FetchCount,
    output logic [31:0] StallCount
`endif
);
    fetch_state_t state, state_next;
    logic [31:0] pc, pc_next, addr, addr_next, target;
    logic taken, capture, valid_next;

    branch_target_unit btu (
        .branch_eq(BranchEQ),
        .branch_ne(BranchNE),
        .zero(Zero),
        .branch_pc4(BranchPC4),
        .branch_imm(BranchImm),
        .taken(taken),
        .target(target)
    );

    always_comb begin
        IMemReq    = (state == IDLE) ? (~taken & (~InstrValid | ~Stall)) : 1'b1;
        capture    = IMemReq & IMemReady & ~taken & (state != DISCARD);
        state_next = (state == IDLE) ? ((IMemReq & ~IMemReady) ? BUSY : IDLE) :
                     IMemReady ? IDLE :
                     (state == DISCARD || taken) ? DISCARD : BUSY;
        pc_next    = taken ? target : capture ? pc + PC_STEP : pc;
        // a wrong-path request keeps its address until memory answers
        addr_next  = (state_next == DISCARD) ? addr : pc_next;
        valid_next = ~taken & (capture | (InstrValid & Stall));
    end

    assign IMemAddr = addr;

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            pc          <= PC_RESET;
            addr        <= PC_RESET;
            InstrValid  <= 1'b0;
            Instruction <= '0;
            PCPlus4     <= '0;
        end else begin
            state      <= state_next;
            pc         <= pc_next;
            addr       <= addr_next;
            InstrValid <= valid_next;
            if (capture) begin
                Instruction <= IMemData;
                PCPlus4     <= pc + PC_STEP;
            end
        end
    end

`ifdef FETCH_PERF_COUNTERS_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            FetchCount <= '0;
            StallCount <= '0;
        end else begin
            FetchCount <= FetchCount + {31'd0, capture};
            StallCount <= StallCount + {31'd0, InstrValid & Stall};
        end
    end
`endif
endmodule

// File: tb/tb_instruction_fetch_unit.sv
// tb_instruction_fetch_unit: directed plus random scoreboard bench for instruction_fetch_unit
module tb_instruction_fetch_unit;
    logic clk = 0;
    logic reset = 1, Stall = 0, BranchEQ = 0, BranchNE = 0, Zero = 0, IMemReady = 0;
    logic [31:0] BranchPC4 = 0, BranchImm = 0, IMemData = 0;
    logic IMemReq, InstrValid;
    logic [31:0] IMemAddr, Instruction, PCPlus4;
`ifdef FETCH_PERF_COUNTERS_EN
    logic [31:0] FetchCount, StallCount;
`endif

    instruction_fetch_unit dut (
        .clk(clk), .reset(reset), .Stall(Stall),
        .BranchEQ(BranchEQ), .BranchNE(BranchNE), .Zero(Zero),
        .BranchPC4(BranchPC4), .BranchImm(BranchImm),
        .IMemReady(IMemReady), .IMemData(IMemData),
        .IMemReq(IMemReq), .IMemAddr(IMemAddr),
        .InstrValid(InstrValid), .Instruction(Instruction), .PCPlus4(PCPlus4)
`ifdef FETCH_PERF_COUNTERS_EN
        , .FetchCount(FetchCount), .StallCount(StallCount)
`endif
    );

    always #5 clk = ~clk;

    typedef struct { logic [31:0] ins; logic [31:0] pc4; } exp_t;
    exp_t exp_q[$];
    logic [31:0] next_pc = 32'h0040_0000, flush_pc = 32'h0040_0000;
    logic flush = 1;
    int checks = 0, errors = 0, delivered = 0;
    logic prev_hold = 0;
    logic [31:0] prev_addr = 0;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h0BAD_F00D;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // The reference is the in-order instruction stream: sequential words from the
    // current PC, restarted at the target on a taken branch or at the base on reset.
    task automatic cyc(input logic rst, input logic st, input logic beq, input logic bne,
                       input logic z, input logic rdy, input logic [31:0] bpc4, input logic [31:0] bimm);
        @(posedge clk);
        #1;
        if (flush) begin
            exp_q.delete();
            next_pc = flush_pc;
        end
        while (exp_q.size() < 8) begin
            exp_q.push_back('{mem_word(next_pc), next_pc + 32'd4});
            next_pc += 32'd4;
        end
        reset = rst; Stall = st; BranchEQ = beq; BranchNE = bne; Zero = z;
        IMemReady = rdy; BranchPC4 = bpc4; BranchImm = bimm;
        IMemData = mem_word(IMemAddr);
        flush = rst | (beq & z) | (bne & ~z);
        flush_pc = rst ? 32'h0040_0000 : bpc4 + bimm * 4;
        @(negedge clk);
    endtask

    task automatic step(input logic st, input logic rdy);
        cyc(0, st, 0, 0, 0, rdy, 0, 0);
    endtask

    always @(negedge clk) begin
        logic tk;
        exp_t e;
        tk = (BranchEQ & Zero) | (BranchNE & ~Zero);
        if (!reset && prev_hold) begin
            chk("req_hold", {31'd0, IMemReq}, 1);
            chk("addr_hold", IMemAddr, prev_addr);
        end
        prev_hold = !reset && IMemReq && !IMemReady;
        prev_addr = IMemAddr;
        if (!reset && InstrValid === 1'b1 && !Stall && !tk) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL sb_empty: got delivery pc4 %h expected none", PCPlus4);
            end else begin
                e = exp_q.pop_front();
                chk("sb_instr", Instruction, e.ins);
                chk("sb_pc4", PCPlus4, e.pc4);
                delivered++;
            end
        end
    end

    initial begin
        cyc(1, 0, 0, 0, 0, 0, 0, 0);
        cyc(1, 0, 0, 0, 0, 0, 0, 0);
        step(0, 1);
        chk("rst_valid", {31'd0, InstrValid}, 0);
        chk("rst_instr", Instruction, 0);
        chk("rst_pc4", PCPlus4, 0);
        chk("rst_req", {31'd0, IMemReq}, 1);
        chk("addr0", IMemAddr, 32'h0040_0000);
        step(0, 1);
        chk("addr1", IMemAddr, 32'h0040_0004);
        chk("valid1", {31'd0, InstrValid}, 1);
        chk("pc4_1", PCPlus4, 32'h0040_0004);
        chk("instr1", Instruction, mem_word(32'h0040_0000));
        step(0, 1);
        chk("addr2", IMemAddr, 32'h0040_0008);
        for (int i = 0; i < 3; i++) begin
            step(0, 0);
            chk("wait_req", {31'd0, IMemReq}, 1);
            chk("wait_addr", IMemAddr, 32'h0040_000C);
            if (i > 0) chk("wait_valid", {31'd0, InstrValid}, 0);
        end
        step(0, 1);
        chk("wait_req4", {31'd0, IMemReq}, 1);
        chk("wait_addr4", IMemAddr, 32'h0040_000C);
        chk("wait_valid4", {31'd0, InstrValid}, 0);
        for (int i = 0; i < 4; i++) begin
            step(1, 1);
            chk("stall_req", {31'd0, IMemReq}, 0);
            chk("stall_valid", {31'd0, InstrValid}, 1);
            chk("stall_pc4", PCPlus4, 32'h0040_0010);
            chk("stall_instr", Instruction, mem_word(32'h0040_000C));
        end
        step(0, 0);
        chk("release_req", {31'd0, IMemReq}, 1);
        chk("release_addr", IMemAddr, 32'h0040_0010);
        cyc(0, 0, 1, 0, 1, 0, 32'h0040_0010, 32'hFFFF_FFFC);
        chk("br_busy_req", {31'd0, IMemReq}, 1);
        chk("br_busy_addr", IMemAddr, 32'h0040_0010);
        step(0, 0);
        chk("discard_req", {31'd0, IMemReq}, 1);
        chk("discard_addr", IMemAddr, 32'h0040_0010);
        step(0, 1);
        chk("discard_addr2", IMemAddr, 32'h0040_0010);
        step(0, 1);
        chk("discard_dropped", {31'd0, InstrValid}, 0);
        chk("target_addr", IMemAddr, 32'h0040_0000);
        chk("target_req", {31'd0, IMemReq}, 1);
        cyc(0, 0, 0, 1, 1, 1, 32'h0050_0000, 32'd8);
        chk("target_valid", {31'd0, InstrValid}, 1);
        chk("target_pc4", PCPlus4, 32'h0040_0004);
        chk("bne_addr", IMemAddr, 32'h0040_0004);
        cyc(0, 1, 1, 0, 1, 1, 32'h0040_0100, 32'd4);
        chk("tk_stall_req", {31'd0, IMemReq}, 0);
        chk("bne_no_redirect", PCPlus4, 32'h0040_0008);
        chk("bne_addr2", IMemAddr, 32'h0040_0008);
        step(0, 0);
        chk("tk_stall_flush", {31'd0, InstrValid}, 0);
        chk("tk_stall_addr", IMemAddr, 32'h0040_0110);
        cyc(1, 0, 0, 0, 0, 0, 0, 0);
        step(0, 0);
        chk("rst_busy_valid", {31'd0, InstrValid}, 0);
        chk("rst_busy_addr", IMemAddr, 32'h0040_0000);
        chk("rst_busy_req", {31'd0, IMemReq}, 1);
        delivered = 0;
        for (int i = 0; i < 4000; i++) begin
            logic br, rst, st, rdy, z;
            logic [31:0] bpc4, imm;
            br = ($urandom_range(0, 15) == 0);
            rst = ($urandom_range(0, 199) == 0);
            st = ($urandom_range(0, 3) == 0);
            rdy = ($urandom_range(0, 9) < 6);
            z = $urandom_range(0, 1);
            bpc4 = 32'h0040_0000 + ($urandom_range(0, 255) << 2);
            imm = $urandom_range(0, 63) - 32;
            cyc(rst, st, br & $urandom_range(0, 1), br & $urandom_range(0, 1), z, rdy, bpc4, imm);
        end
        chk("throughput", {31'd0, delivered > 500}, 1);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end
endmodule
